// File: rtl/tlul_xbar_param.sv
// TL-UL crossbar: NumHosts hosts to NumDevices devices.
// Per-device round-robin, table decode, per-host error responder.
package tlul_pkg;
  localparam logic [2:0] OpPutFull    = 3'h0;
  localparam logic [2:0] OpPutPartial = 3'h1;
  localparam logic [2:0] OpGet        = 3'h4;
  localparam logic [2:0] OpAck        = 3'h0;
  localparam logic [2:0] OpAckData    = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [13:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// Response integrity: header code in d_user[13:7],
// data code in d_user[6:0].
module tlul_rsp_intg_gen
  import tlul_pkg::*;
(
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);
  logic [6:0] w_rsp;
  logic [6:0] w_dat;

  assign w_rsp = {
    ^tl_i.d_opcode,
    ^tl_i.d_size,
    tl_i.d_error,
    ^tl_i.d_source,
    ^tl_i.d_param,
    tl_i.d_sink,
    ^{tl_i.d_opcode, tl_i.d_size, tl_i.d_error}
  };

  assign w_dat = {
    ^tl_i.d_data,
    ^tl_i.d_data[29:25],
    ^tl_i.d_data[24:20],
    ^tl_i.d_data[19:15],
    ^tl_i.d_data[14:10],
    ^tl_i.d_data[9:5],
    ^tl_i.d_data[4:0]
  };

  // Pass the response through with the integrity field filled in
  always_comb begin
    tl_o = tl_i;
    tl_o.d_user = {w_rsp, w_dat};
  end
endmodule

module tlul_xbar_param
  import tlul_pkg::*;
#(
  parameter int unsigned NumHosts   = 2,
  parameter int unsigned NumDevices = 3,
  parameter logic [NumDevices-1:0][31:0] DevBase = {
    32'h4000_1000, 32'h4000_0000, 32'h0000_0000
  },
  parameter logic [NumDevices-1:0][31:0] DevMask = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F800
  }
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i [NumHosts],
  output tl_d2h_t tl_h_o [NumHosts],
  output tl_h2d_t tl_d_o [NumDevices],
  input  tl_d2h_t tl_d_i [NumDevices]
);
  localparam int unsigned HW =
    (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int unsigned DW =
    (NumDevices > 1) ? $clog2(NumDevices) : 1;

  function automatic logic [HW-1:0] wrap(
    input int unsigned v
  );
    return HW'(v % NumHosts);
  endfunction

  logic                  r_active;
  logic [NumHosts-1:0]   r_busy;
  logic [NumHosts-1:0]   r_err_vld;
  logic [2:0]            r_err_op   [NumHosts];
  logic [1:0]            r_err_size [NumHosts];
  logic [7:0]            r_err_src  [NumHosts];
  logic [NumDevices-1:0] r_wait;
  logic [NumDevices-1:0] r_lock;
  logic [HW-1:0]         r_owner [NumDevices];
  logic [HW-1:0]         r_rr    [NumDevices];

  logic [NumHosts-1:0]   w_hit;
  logic [DW-1:0]         w_dev [NumHosts];
  logic [NumHosts-1:0]   w_req [NumDevices];
  logic [NumDevices-1:0] w_gnt_vld;
  logic [HW-1:0]         w_gnt [NumDevices];
  logic [NumDevices-1:0] w_a_hs;
  logic [NumDevices-1:0] w_d_hs;
  logic [NumHosts-1:0]   w_h_a_hs;
  logic [NumHosts-1:0]   w_h_d_hs;
  tl_d2h_t               w_err_raw [NumHosts];
  tl_d2h_t               w_err_rsp [NumHosts];

  // Address decode; scanning downwards lets the lowest hit win
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      w_hit[h] = 1'b0;
      w_dev[h] = '0;
      for (int d = NumDevices - 1; d >= 0; d--) begin
        if ((tl_h_i[h].a_address & DevMask[d])
            == DevBase[d]) begin
          w_hit[h] = 1'b1;
          w_dev[h] = DW'(d);
        end
      end
    end
  end

  // Request matrix: live, non-busy hosts per device
  always_comb begin
    for (int d = 0; d < NumDevices; d++) begin
      w_req[d] = '0;
      for (int h = 0; h < NumHosts; h++) begin
        w_req[d][h] = r_active
          && tl_h_i[h].a_valid
          && !r_busy[h]
          && w_hit[h]
          && (w_dev[h] == DW'(d));
      end
    end
  end

  // Grant: locked host if stalled, else first requester from r_rr
  always_comb begin
    for (int d = 0; d < NumDevices; d++) begin
      w_gnt_vld[d] = 1'b0;
      w_gnt[d]     = '0;
      if (r_active && !r_wait[d]) begin
        if (r_lock[d]) begin
          w_gnt_vld[d] = 1'b1;
          w_gnt[d]     = r_owner[d];
        end else begin
          for (int i = NumHosts - 1; i >= 0; i--) begin
            if (w_req[d][wrap(32'(r_rr[d]) + 32'(i))]) begin
              w_gnt_vld[d] = 1'b1;
              w_gnt[d] = wrap(32'(r_rr[d]) + 32'(i));
            end
          end
        end
      end
    end
  end

  // Device-side a-channel mux and d_ready return path
  always_comb begin
    for (int d = 0; d < NumDevices; d++) begin
      tl_d_o[d] = '0;
      if (w_gnt_vld[d]) begin
        tl_d_o[d] = tl_h_i[w_gnt[d]];
        tl_d_o[d].a_valid = w_req[d][w_gnt[d]];
        tl_d_o[d].d_ready = 1'b0;
      end else if (r_wait[d]) begin
        tl_d_o[d].d_ready =
          tl_h_i[r_owner[d]].d_ready;
      end
      w_a_hs[d] = tl_d_o[d].a_valid
        & tl_d_i[d].a_ready;
      w_d_hs[d] = r_wait[d]
        & tl_d_i[d].d_valid
        & tl_d_o[d].d_ready;
    end
  end

  // Error responder payload from the captured request
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      w_err_raw[h] = '0;
      w_err_raw[h].d_valid  = r_err_vld[h];
      w_err_raw[h].d_opcode = r_err_op[h];
      w_err_raw[h].d_size   = r_err_size[h];
      w_err_raw[h].d_source = r_err_src[h];
      w_err_raw[h].d_data   = 32'hFFFF_FFFF;
      w_err_raw[h].d_error  = 1'b1;
    end
  end

  for (genvar h = 0; h < NumHosts; h++) begin : g_intg
    tlul_rsp_intg_gen u_intg (
      .tl_i (w_err_raw[h]),
      .tl_o (w_err_rsp[h])
    );
  end

  // Host-side d-channel mux and a_ready
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      tl_h_o[h] = '0;
      for (int d = 0; d < NumDevices; d++) begin
        if (r_wait[d] && r_owner[d] == HW'(h)) begin
          tl_h_o[h] = tl_d_i[d];
        end
      end
      if (r_err_vld[h]) begin
        tl_h_o[h] = w_err_rsp[h];
      end
      tl_h_o[h].a_ready = 1'b0;
      if (r_active && !r_busy[h]) begin
        if (!w_hit[h]) begin
          tl_h_o[h].a_ready = 1'b1;
        end else begin
          tl_h_o[h].a_ready =
            w_gnt_vld[w_dev[h]]
            && (w_gnt[w_dev[h]] == HW'(h))
            && tl_d_i[w_dev[h]].a_ready;
        end
      end
      w_h_a_hs[h] = tl_h_i[h].a_valid
        & tl_h_o[h].a_ready;
      w_h_d_hs[h] = tl_h_o[h].d_valid
        & tl_h_i[h].d_ready;
    end
  end

  // Outputs stay quiet until the first edge after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  // Per-host outstanding flag and error responder capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy    <= '0;
      r_err_vld <= '0;
      for (int h = 0; h < NumHosts; h++) begin
        r_err_op[h]   <= '0;
        r_err_size[h] <= '0;
        r_err_src[h]  <= '0;
      end
    end else begin
      for (int h = 0; h < NumHosts; h++) begin
        if (w_h_a_hs[h]) begin
          r_busy[h] <= 1'b1;
          if (!w_hit[h]) begin
            r_err_vld[h]  <= 1'b1;
            r_err_op[h]   <=
              (tl_h_i[h].a_opcode == OpGet)
              ? OpAckData : OpAck;
            r_err_size[h] <= tl_h_i[h].a_size;
            r_err_src[h]  <= tl_h_i[h].a_source;
          end
        end else if (w_h_d_hs[h]) begin
          r_busy[h]    <= 1'b0;
          r_err_vld[h] <= 1'b0;
        end
      end
    end
  end

  // Per-device IDLE/WAIT, grant lock, owner and rr pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait <= '0;
      r_lock <= '0;
      for (int d = 0; d < NumDevices; d++) begin
        r_owner[d] <= '0;
        r_rr[d]    <= '0;
      end
    end else begin
      for (int d = 0; d < NumDevices; d++) begin
        if (!r_wait[d]) begin
          if (w_a_hs[d]) begin
            r_wait[d]  <= 1'b1;
            r_lock[d]  <= 1'b0;
            r_owner[d] <= w_gnt[d];
            r_rr[d]    <= wrap(32'(w_gnt[d]) + 32'd1);
          end else if (tl_d_o[d].a_valid) begin
            r_lock[d]  <= 1'b1;
            r_owner[d] <= w_gnt[d];
          end
        end else if (w_d_hs[d]) begin
          r_wait[d] <= 1'b0;
        end
      end
    end
  end

  for (genvar d = 0; d < NumDevices; d++) begin : g_chk
    a_no_idle_dvalid : assert property (
      @(posedge clk_i) disable iff (!rst_ni || !r_active)
      !(tl_d_i[d].d_valid && !r_wait[d])
    );
  end
endmodule

// File: tb/tb_tlul_xbar_param.sv
// Directed bench for tlul_xbar_param.
// Hosts and devices are driven by hand; responses checked per cycle.
module tb_tlul_xbar_param;
  import tlul_pkg::*;

  logic    clk;
  logic    rst_n;
  tl_h2d_t h_i [2];
  tl_d2h_t h_o [2];
  tl_h2d_t d_o [3];
  tl_d2h_t d_i [3];

  int n_chk;
  int n_fail;

  tlul_xbar_param dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tl_h_i (h_i),
    .tl_h_o (h_o),
    .tl_d_o (d_o),
    .tl_d_i (d_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(
    input int          h,
    input logic [2:0]  op,
    input logic [31:0] addr,
    input logic [7:0]  src,
    input logic [31:0] data
  );
    h_i[h].a_valid   = 1'b1;
    h_i[h].a_opcode  = op;
    h_i[h].a_size    = 2'd2;
    h_i[h].a_source  = src;
    h_i[h].a_address = addr;
    h_i[h].a_mask    = 4'hF;
    h_i[h].a_data    = data;
  endtask

  task automatic hidle(input int h);
    h_i[h].a_valid = 1'b0;
  endtask

  task automatic rsp(
    input int          d,
    input logic [2:0]  op,
    input logic [7:0]  src,
    input logic [31:0] data
  );
    d_i[d].d_valid  = 1'b1;
    d_i[d].d_opcode = op;
    d_i[d].d_size   = 2'd2;
    d_i[d].d_source = src;
    d_i[d].d_data   = data;
  endtask

  task automatic didle(input int d);
    d_i[d].d_valid = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int h = 0; h < 2; h++) begin
      h_i[h] = '0;
      h_i[h].d_ready = 1'b1;
    end
    for (int d = 0; d < 3; d++) d_i[d] = '0;
    req(1, OpGet, 32'h7000_0000, 8'h01, 32'h0);
    #2;
    chk("rst_h1_ardy", h_o[1].a_ready, 0);
    chk("rst_h0_dvld", h_o[0].d_valid, 0);
    chk("rst_ram_avld", d_o[0].a_valid, 0);
    hidle(1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1. round-robin alternation on ram
    d_i[0].a_ready = 1'b1;
    req(0, OpGet, 32'h0000_0010, 8'h11, 32'h0);
    req(1, OpGet, 32'h0000_0010, 8'h22, 32'h0);
    #1;
    chk("rr1_src", d_o[0].a_source, 8'h11);
    chk("rr1_h0rdy", h_o[0].a_ready, 1);
    chk("rr1_h1rdy", h_o[1].a_ready, 0);
    tick();
    hidle(0);
    #1;
    chk("rr1_wait_h1rdy", h_o[1].a_ready, 0);
    chk("rr1_wait_avld", d_o[0].a_valid, 0);
    rsp(0, OpAckData, 8'h11, 32'h0000_AAAA);
    #1;
    chk("rr1_h0_dvld", h_o[0].d_valid, 1);
    chk("rr1_h0_data", h_o[0].d_data, 32'h0000_AAAA);
    chk("rr1_h1_dvld", h_o[1].d_valid, 0);
    chk("rr1_ram_drdy", d_o[0].d_ready, 1);
    chk("rr1_same_cyc", h_o[1].a_ready, 0);
    tick();
    didle(0);
    req(0, OpGet, 32'h0000_0010, 8'h13, 32'h0);
    #1;
    chk("rr2_src", d_o[0].a_source, 8'h22);
    chk("rr2_h1rdy", h_o[1].a_ready, 1);
    chk("rr2_h0rdy", h_o[0].a_ready, 0);
    tick();
    hidle(1);
    rsp(0, OpAckData, 8'h22, 32'h0000_BBBB);
    #1;
    chk("rr2_h1_dvld", h_o[1].d_valid, 1);
    chk("rr2_h0_dvld", h_o[0].d_valid, 0);
    tick();
    didle(0);
    #1;
    chk("rr3_src", d_o[0].a_source, 8'h13);
    chk("rr3_h0rdy", h_o[0].a_ready, 1);
    tick();
    hidle(0);
    rsp(0, OpAckData, 8'h13, 32'h0);
    #1;
    chk("rr3_h0_dvld", h_o[0].d_valid, 1);
    tick();
    didle(0);

    // 2. unmapped address -> error responder
    req(1, OpGet, 32'h7000_0000, 8'h5A, 32'h0);
    #1;
    chk("err_ardy", h_o[1].a_ready, 1);
    chk("err_no_dev",
        {d_o[0].a_valid, d_o[1].a_valid, d_o[2].a_valid},
        3'b000);
    chk("err_no_dvld_yet", h_o[1].d_valid, 0);
    tick();
    hidle(1);
    #1;
    chk("err_dvld", h_o[1].d_valid, 1);
    chk("err_derr", h_o[1].d_error, 1);
    chk("err_data", h_o[1].d_data, 32'hFFFF_FFFF);
    chk("err_src", h_o[1].d_source, 8'h5A);
    chk("err_op_get", h_o[1].d_opcode, OpAckData);
    chk("err_size", h_o[1].d_size, 2'd2);
    tick();
    chk("err_done", h_o[1].d_valid, 0);
    req(0, OpPutFull, 32'h8000_0000, 8'h03, 32'h1);
    tick();
    hidle(0);
    #1;
    chk("err_op_put", h_o[0].d_opcode, OpAck);
    chk("err_put_src", h_o[0].d_source, 8'h03);
    tick();

    // 3. grant lock on uart; warm-up moves rr to host 1
    d_i[1].a_ready = 1'b1;
    req(0, OpPutFull, 32'h4000_0000, 8'h0F, 32'h0);
    tick();
    hidle(0);
    rsp(1, OpAck, 8'h0F, 32'h0);
    tick();
    didle(1);
    d_i[1].a_ready = 1'b0;
    req(0, OpPutFull, 32'h4000_0004, 8'h01, 32'hDEAD_BEEF);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req(1, OpPutFull, 32'h4000_0008, 8'h02, 32'h1234);
      end
      #1;
      chk("lock_src", d_o[1].a_source, 8'h01);
      chk("lock_data", d_o[1].a_data, 32'hDEAD_BEEF);
      chk("lock_h0rdy", h_o[0].a_ready, 0);
      tick();
    end
    d_i[1].a_ready = 1'b1;
    #1;
    chk("lock_acc_src", d_o[1].a_source, 8'h01);
    chk("lock_acc_h0", h_o[0].a_ready, 1);
    chk("lock_acc_h1", h_o[1].a_ready, 0);
    tick();
    hidle(0);
    rsp(1, OpAck, 8'h01, 32'h0);
    #1;
    chk("lock_rsp_h0", h_o[0].d_valid, 1);
    tick();
    didle(1);
    #1;
    chk("lock_next_src", d_o[1].a_source, 8'h02);
    chk("lock_next_h1", h_o[1].a_ready, 1);
    tick();
    hidle(1);
    rsp(1, OpAck, 8'h02, 32'h0);
    #1;
    chk("lock_rsp_h1", h_o[1].d_valid, 1);
    tick();
    didle(1);

    // 4. single outstanding per host (gpio)
    d_i[2].a_ready = 1'b1;
    req(0, OpPutFull, 32'h4000_1008, 8'h06, 32'h5);
    #1;
    chk("one_first_rdy", h_o[0].a_ready, 1);
    tick();
    req(0, OpPutFull, 32'h4000_1008, 8'h07, 32'h6);
    #1;
    chk("one_busy_rdy", h_o[0].a_ready, 0);
    chk("one_busy_avld", d_o[2].a_valid, 0);
    tick();
    chk("one_busy_rdy2", h_o[0].a_ready, 0);
    rsp(2, OpAck, 8'h06, 32'h0);
    #1;
    chk("one_rsp_vld", h_o[0].d_valid, 1);
    chk("one_rsp_op", h_o[0].d_opcode, OpAck);
    chk("one_rsp_rdy", h_o[0].a_ready, 0);
    tick();
    didle(2);
    #1;
    chk("one_free_rdy", h_o[0].a_ready, 1);
    chk("one_free_src", d_o[2].a_source, 8'h07);
    tick();
    hidle(0);
    rsp(2, OpAck, 8'h07, 32'h0);
    tick();
    didle(2);

    // 5. parallel devices
    req(0, OpGet, 32'h0000_0020, 8'h31, 32'h0);
    req(1, OpPutFull, 32'h4000_1000, 8'h32, 32'h9);
    #1;
    chk("par_h0rdy", h_o[0].a_ready, 1);
    chk("par_h1rdy", h_o[1].a_ready, 1);
    chk("par_ram_src", d_o[0].a_source, 8'h31);
    chk("par_gpio_src", d_o[2].a_source, 8'h32);
    tick();
    hidle(0);
    hidle(1);
    rsp(0, OpAckData, 8'h31, 32'h1111_0000);
    rsp(2, OpAck, 8'h32, 32'h0);
    #1;
    chk("par_h0_data", h_o[0].d_data, 32'h1111_0000);
    chk("par_h0_src", h_o[0].d_source, 8'h31);
    chk("par_h1_src", h_o[1].d_source, 8'h32);
    chk("par_h1_op", h_o[1].d_opcode, OpAck);
    tick();
    didle(0);
    didle(2);

    // 6. reset while ram waits for its response
    req(0, OpGet, 32'h0000_0030, 8'h41, 32'h0);
    tick();
    hidle(0);
    req(1, OpGet, 32'h0000_0030, 8'h42, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mrst_h1rdy", h_o[1].a_ready, 0);
    chk("mrst_ram_avld", d_o[0].a_valid, 0);
    rsp(0, OpAckData, 8'h41, 32'hCAFE_0000);
    #1;
    chk("mrst_h0_dvld", h_o[0].d_valid, 0);
    chk("mrst_ram_drdy", d_o[0].d_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_h0_dvld", h_o[0].d_valid, 0);
    chk("post_h1_dvld", h_o[1].d_valid, 0);
    didle(0);
    tick();
    req(0, OpGet, 32'h0000_0040, 8'h51, 32'h0);
    req(1, OpGet, 32'h0000_0040, 8'h52, 32'h0);
    #1;
    chk("post_src", d_o[0].a_source, 8'h51);
    chk("post_h0rdy", h_o[0].a_ready, 1);
    tick();
    hidle(0);
    hidle(1);
    rsp(0, OpAckData, 8'h51, 32'h0);
    #1;
    chk("post_rsp", h_o[0].d_valid, 1);
    tick();
    didle(0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule
